// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit and the control
// FSM that waits on it.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } mdu_state_e;

  // Division ops share the upper op bit.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  // Signed ops have a zero in the low op bit.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negation: magnitude extraction on operand
// capture and sign restoration on the final result.
module mdu_sign_fix #(
  parameter int N = 32
) (
  input  logic [N-1:0] val,
  input  logic         neg,
  output logic [N-1:0] res
);

  // Negate when requested, pass through otherwise.
  always_comb begin
    res = neg ? (~val + {{(N-1){1'b0}}, 1'b1}) : val;
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring-subtract step
// per cycle on operand magnitudes, followed by a sign-correction cycle.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam int AW = 2 * WIDTH + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  mdu_state_e     state;
  logic [CW-1:0]  cnt;
  logic           is_div_q;
  logic           neg_main_q;
  logic           neg_rem_q;
  logic [WIDTH-1:0] opb_q;
  logic [AW-1:0]  acc;

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic             sgn;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign a_s   = a;
  assign b_s   = b;
  assign sgn   = op_is_signed(op);
  assign a_neg = sgn && (a_s < 0);
  assign b_neg = sgn && (b_s < 0);

  mdu_sign_fix #(.N(WIDTH)) u_mag_a (.val(a), .neg(a_neg), .res(a_mag));
  mdu_sign_fix #(.N(WIDTH)) u_mag_b (.val(b), .neg(b_neg), .res(b_mag));

  logic [WIDTH:0]   madd;
  logic [AW-1:0]    mult_next;
  logic [AW-1:0]    dsh;
  logic [WIDTH+1:0] trial;
  logic [AW-1:0]    div_next;
  logic [AW-1:0]    step_next;

  // One iteration: multiplier sits in the low half and shifts out to the right;
  // dividend shifts left into the guarded upper half for the trial subtract.
  always_comb begin
    madd      = acc[AW-1:WIDTH] + (acc[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    mult_next = {madd, acc[WIDTH-1:0]} >> 1;
    dsh       = acc << 1;
    trial     = {1'b0, dsh[AW-1:WIDTH]} - {2'b00, opb_q};
    div_next  = trial[WIDTH+1] ? dsh : {trial[WIDTH:0], dsh[WIDTH-1:1], 1'b1};
    step_next = is_div_q ? div_next : mult_next;
  end

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  mdu_sign_fix #(.N(2*WIDTH)) u_fix_prod (.val(acc[2*WIDTH-1:0]),     .neg(neg_main_q), .res(prod_fix));
  mdu_sign_fix #(.N(WIDTH))   u_fix_quo  (.val(acc[WIDTH-1:0]),       .neg(neg_main_q), .res(quo_fix));
  mdu_sign_fix #(.N(WIDTH))   u_fix_rem  (.val(acc[2*WIDTH-1:WIDTH]), .neg(neg_rem_q),  .res(rem_fix));

  // Datapath registers: capture magnitudes and sign flags on accept, iterate in CALC.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      is_div_q   <= op_is_div(op);
      neg_main_q <= a_neg ^ b_neg;
      neg_rem_q  <= a_neg;
      opb_q      <= b_mag;
      acc        <= {{(WIDTH+1){1'b0}}, a_mag};
    end else if (state == CALC) begin
      acc <= step_next;
    end
  end

  // Control FSM with registered handshake outputs and result write in FIX.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (op_is_div(op) && (b == '0)) begin
              state    <= DONE;
              done     <= 1'b1;
              div_zero <= 1'b1;
            end else begin
              state <= CALC;
              cnt   <= CNT_INIT;
            end
          end
        end
        CALC: begin
          if (cnt == '0) begin
            state <= FIX;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        FIX: begin
          {hi, lo} <= is_div_q ? {rem_fix, quo_fix} : prod_fix;
          done     <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit at WIDTH=32 and WIDTH=8.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        start32 = 1'b0;
  logic [1:0]  op32 = 2'b00;
  logic [31:0] a32 = '0, b32 = '0;
  logic [31:0] hi32, lo32;
  logic        busy32, done32, dz32;

  logic        start8 = 1'b0;
  logic [1:0]  op8 = 2'b00;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [7:0]  hi8, lo8;
  logic        busy8, done8, dz8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
    .hi(hi32), .lo(lo32), .busy(busy32), .done(done32), .div_zero(dz32)
  );

  mult_div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .hi(hi8), .lo(lo8), .busy(busy8), .done(done8), .div_zero(dz8)
  );

  // Issue one op on the 32-bit unit; lat counts cycles from the accepting edge.
  task automatic run32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, output int lat);
    @(negedge clk);
    op32 = o; a32 = x; b32 = y; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    lat = 1;
    while (done32 !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y, output int lat);
    @(negedge clk);
    op8 = o; a8 = x; b8 = y; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 1;
    while (done8 !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({hi32, lo32, busy32, done32, dz32} !== 67'd0) begin errors++; $display("FAIL reset32 got hi=%h lo=%h busy=%b done=%b dz=%b exp all zero", hi32, lo32, busy32, done32, dz32); end
    checks++; if ({hi8, lo8, busy8, done8, dz8} !== 19'd0) begin errors++; $display("FAIL reset8 got hi=%h lo=%h busy=%b done=%b dz=%b exp all zero", hi8, lo8, busy8, done8, dz8); end
    reset = 1'b0;
  endtask

  task automatic test_mult();
    int lat;
    run32(2'b00, 32'd7, 32'hFFFFFFFD, lat);
    checks++; if (lat !== 34) begin errors++; $display("FAIL mult_latency got=%0d exp=34", lat); end
    checks++; if ({hi32, lo32} !== 64'hFFFFFFFF_FFFFFFEB) begin errors++; $display("FAIL mult_neg got=%h_%h exp=ffffffff_ffffffeb", hi32, lo32); end
    checks++; if (dz32 !== 1'b0) begin errors++; $display("FAIL mult_dz got=%b exp=0", dz32); end
    @(negedge clk);
    checks++; if ({busy32, done32} !== 2'b00) begin errors++; $display("FAIL mult_after_done got busy=%b done=%b exp 0 0", busy32, done32); end
    run32(2'b00, 32'hFFFFFFFD, 32'hFFFFFFFD, lat);
    checks++; if ({hi32, lo32} !== 64'h00000000_00000009) begin errors++; $display("FAIL mult_negneg got=%h_%h exp=00000000_00000009", hi32, lo32); end
  endtask

  task automatic test_unsigned();
    int lat;
    run32(2'b01, 32'hFFFFFFFF, 32'd2, lat);
    checks++; if ({hi32, lo32} !== 64'h00000001_FFFFFFFE) begin errors++; $display("FAIL multu got=%h_%h exp=00000001_fffffffe", hi32, lo32); end
    run32(2'b11, 32'd100, 32'd7, lat);
    checks++; if (lat !== 34) begin errors++; $display("FAIL divu_latency got=%0d exp=34", lat); end
    checks++; if ({hi32, lo32} !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu got hi=%0d lo=%0d exp hi=2 lo=14", hi32, lo32); end
  endtask

  task automatic test_div();
    int lat;
    run32(2'b10, 32'hFFFFFFF9, 32'd2, lat);
    checks++; if ({hi32, lo32} !== 64'hFFFFFFFF_FFFFFFFD) begin errors++; $display("FAIL div_neg_dividend got=%h_%h exp=ffffffff_fffffffd", hi32, lo32); end
    run32(2'b10, 32'd7, 32'hFFFFFFFE, lat);
    checks++; if ({hi32, lo32} !== 64'h00000001_FFFFFFFD) begin errors++; $display("FAIL div_neg_divisor got=%h_%h exp=00000001_fffffffd", hi32, lo32); end
    run32(2'b10, 32'h80000000, 32'hFFFFFFFF, lat);
    checks++; if ({hi32, lo32} !== 64'h00000000_80000000) begin errors++; $display("FAIL div_overflow got=%h_%h exp=00000000_80000000", hi32, lo32); end
    checks++; if (dz32 !== 1'b0) begin errors++; $display("FAIL div_overflow_dz got=%b exp=0", dz32); end
  endtask

  task automatic test_div_zero();
    int lat;
    run32(2'b11, 32'h451, 32'h20, lat);
    checks++; if ({hi32, lo32} !== {32'h11, 32'h22}) begin errors++; $display("FAIL preload got hi=%h lo=%h exp hi=11 lo=22", hi32, lo32); end
    run32(2'b10, 32'd5, 32'd0, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL divzero_latency got=%0d exp=1", lat); end
    checks++; if ({dz32, busy32} !== 2'b11) begin errors++; $display("FAIL divzero_flags got dz=%b busy=%b exp 1 1", dz32, busy32); end
    checks++; if ({hi32, lo32} !== {32'h11, 32'h22}) begin errors++; $display("FAIL divzero_hold got hi=%h lo=%h exp hi=11 lo=22", hi32, lo32); end
    @(negedge clk);
    checks++; if ({busy32, done32, dz32} !== 3'b000) begin errors++; $display("FAIL divzero_after got busy=%b done=%b dz=%b exp 0 0 0", busy32, done32, dz32); end
  endtask

  task automatic test_back_to_back();
    int ndone = 0;
    int first = 0;
    logic [31:0] h = '0, l = '0;
    @(negedge clk);
    op32 = 2'b00; a32 = 32'd7; b32 = 32'hFFFFFFFD; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (done32 === 1'b1) begin
        ndone++;
        if (first == 0) begin first = c; h = hi32; l = lo32; end
      end
      if (c == 5) begin op32 = 2'b01; a32 = 32'hFFFFFFFF; b32 = 32'd2; start32 = 1'b1; end
      if (c == 6) start32 = 1'b0;
      @(negedge clk);
    end
    checks++; if (first !== 34) begin errors++; $display("FAIL ignore_start_latency got=%0d exp=34", first); end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL ignore_start_dones got=%0d exp=1", ndone); end
    checks++; if ({h, l} !== 64'hFFFFFFFF_FFFFFFEB) begin errors++; $display("FAIL ignore_start_result got=%h_%h exp=ffffffff_ffffffeb", h, l); end
  endtask

  task automatic test_reset_abort();
    int lat;
    int ndone = 0;
    @(negedge clk);
    op32 = 2'b00; a32 = 32'd7; b32 = 32'hFFFFFFFD; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if ({busy32, done32, hi32, lo32} !== 66'd0) begin errors++; $display("FAIL abort_state got busy=%b done=%b hi=%h lo=%h exp all zero", busy32, done32, hi32, lo32); end
    reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done32 === 1'b1) ndone++;
      @(negedge clk);
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", ndone); end
    reset = 1'b1; start32 = 1'b1;
    @(negedge clk);
    reset = 1'b0; start32 = 1'b0;
    @(negedge clk);
    checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL reset_beats_start got busy=%b exp=0", busy32); end
    run32(2'b01, 32'hFFFFFFFF, 32'd2, lat);
    checks++; if (lat !== 34 || {hi32, lo32} !== 64'h00000001_FFFFFFFE) begin errors++; $display("FAIL after_abort got lat=%0d %h_%h exp lat=34 00000001_fffffffe", lat, hi32, lo32); end
  endtask

  task automatic test_width8();
    int lat;
    run8(2'b00, 8'd7, 8'hFD, lat);
    checks++; if (lat !== 10) begin errors++; $display("FAIL w8_mult_latency got=%0d exp=10", lat); end
    checks++; if ({hi8, lo8} !== 16'hFFEB) begin errors++; $display("FAIL w8_mult got=%h exp=ffeb", {hi8, lo8}); end
    run8(2'b10, 8'hF9, 8'd2, lat);
    checks++; if (lat !== 10) begin errors++; $display("FAIL w8_div_latency got=%0d exp=10", lat); end
    checks++; if ({hi8, lo8} !== 16'hFFFD) begin errors++; $display("FAIL w8_div got=%h exp=fffd", {hi8, lo8}); end
    run8(2'b10, 8'h80, 8'hFF, lat);
    checks++; if ({hi8, lo8} !== 16'h0080) begin errors++; $display("FAIL w8_div_overflow got=%h exp=0080", {hi8, lo8}); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_unsigned();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_reset_abort();
    test_width8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
